alu_cmd_issuer: RTL

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// Command issuer: queues ALU commands in a small FIFO, issues them one at a time
// to an external combinational ALU, and holds each captured result until taken.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  input  logic [2:0]             cmd_op,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_op,
  input  logic [WIDTH-1:0]       alu_z,
  input  logic                   alu_cout,
  input  logic                   alu_sign,
  input  logic                   alu_ov,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_z,
  output logic [2:0]             res_flags,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * WIDTH + 3;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [EW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  state_t           state_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [2:0]       alu_op_r;
  logic             res_valid_r;
  logic [WIDTH-1:0] res_z_r;
  logic [2:0]       res_flags_r;
  logic             busy_r;

  logic             push_s;
  logic             pop_s;
  logic [EW-1:0]    head_s;

  // Pop decision uses pre-edge occupancy, so a command pushed into an empty FIFO waits one edge.
  assign cmd_ready = (count_r < FULL_CNT);
  assign push_s    = cmd_valid & cmd_ready;
  assign pop_s     = (state_r == IDLE) && (count_r != {CW{1'b0}});
  assign head_s    = mem_r[rd_ptr_r];

  // FIFO storage write; contents are don't-care while the entry is not occupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue FSM with registered ALU operands, result capture and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      alu_a_r     <= {WIDTH{1'b0}};
      alu_b_r     <= {WIDTH{1'b0}};
      alu_op_r    <= 3'b000;
      res_valid_r <= 1'b0;
      res_z_r     <= {WIDTH{1'b0}};
      res_flags_r <= 3'b000;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            alu_op_r <= head_s[EW-1 -: 3];
            alu_a_r  <= head_s[2*WIDTH-1 -: WIDTH];
            alu_b_r  <= head_s[WIDTH-1:0];
            busy_r   <= 1'b1;
            state_r  <= EXEC;
          end
        end
        EXEC: begin
          res_z_r     <= alu_z;
          res_flags_r <= {alu_cout, alu_sign, alu_ov};
          res_valid_r <= 1'b1;
          state_r     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_op     = alu_op_r;
  assign res_valid  = res_valid_r;
  assign res_z      = res_z_r;
  assign res_flags  = res_flags_r;
  assign fifo_count = count_r;
  assign busy       = busy_r;

endmodule
